uart2_tx: RTL and testbench

Variable-baud UART transmitter paired with `uart2_rx`. It carries readback and status bytes (polled via `poll_uart`) from the FPGA to the host over the serial link. A 4-deep byte FIFO absorbs bursts from the register/readback logic, and frames are serialised as 8N1 (optionally 8E1) on `tx_out`. `tx_out` can be looped straight into `uart2_rx.rx_in` for self-test.

---
 rtl/uart2_pkg.sv | 18 +
 rtl/uart2_tx_fifo.sv | 50 +++++
 rtl/uart2_tx.sv | 143 ++++++++++++++
 tb/tb_uart2_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart2_pkg.sv
// Shared definitions for the uart2 transmitter/receiver pair: FSM state encoding
// and the elaboration-time baud divisor.
package uart2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Rounded clocks-per-bit, e.g. 4167 for 40 MHz at 9600 baud.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart2_tx_fifo.sv
// Small synchronous byte FIFO in front of the uart2 serialiser. A write while full
// is dropped and flagged, unless a pop in the same cycle frees the slot.
module uart2_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW:0]     wr_ptr;
    logic [FIFO_AW:0]     rd_ptr;
    logic                 wr_ok;
    logic                 rd_ok;

    // Extra pointer MSB separates full from empty when the addresses match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign rd_ok   = rd && !empty;
    assign wr_ok   = wr && (!full || rd_ok);
    assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            overflow <= wr && full && !rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart2_tx.sv
// Variable-baud UART transmitter, 8N1 by default; defining UART2_TX_PARITY_EN
// adds an even-parity bit (8E1). A 4-deep FIFO buffers outgoing bytes.
module uart2_tx
    import uart2_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int CLK_FREQ  = 40000000,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 ld_tx_data,
    input  logic                 tx_enable,
    output logic                 tx_out,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 tx_overflow
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 bit_done;
    logic                 pop;
`ifdef UART2_TX_PARITY_EN
    logic                 parity;
`endif

    uart2_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .FIFO_AW   (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (ld_tx_data),
        .wr_data  (tx_data),
        .rd       (pop),
        .rd_data  (fifo_data),
        .full     (tx_full),
        .empty    (fifo_empty),
        .overflow (tx_overflow)
    );

    assign bit_done = (cnt == CNT_LAST);
    // A new frame may start from IDLE or straight out of the last STOP cycle.
    assign pop      = !fifo_empty && tx_enable &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
    assign tx_empty = fifo_empty && (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx_out  <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART2_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (pop) begin
            state   <= ST_START;
            tx_out  <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= fifo_data;
`ifdef UART2_TX_PARITY_EN
            parity  <= ^fifo_data;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_out <= 1'b1;
                end
                ST_START: begin
                    if (bit_done) begin
                        state  <= ST_DATA;
                        tx_out <= shift[0];
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART2_TX_PARITY_EN
                            state  <= ST_PARITY;
                            tx_out <= parity;
`else
                            state  <= ST_STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx_out  <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART2_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state  <= ST_STOP;
                        tx_out <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        state  <= ST_IDLE;
                        tx_out <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_out <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart2_tx.sv
// Bench for uart2_tx at a reduced divisor (80 Hz / 10 baud -> 8 clocks per bit):
// frame vector table, burst/overflow, enable gating, mid-frame enable drop and reset.
`timescale 1ns/1ps
module tb_uart2_tx;

    localparam int DIV = 8;
`ifdef UART2_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       ld_tx_data;
    logic       tx_enable;
    logic       tx_out;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_overflow;

    uart2_tx #(
        .DATA_BITS (8),
        .BAUD      (10),
        .CLK_FREQ  (80),
        .FIFO_AW   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .ld_tx_data  (ld_tx_data),
        .tx_enable   (tx_enable),
        .tx_out      (tx_out),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int unsigned start_q[$];
    bit mon_en = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line level per bit period: [0]=start .. [9]=stop
        logic       par;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int k);
`ifdef UART2_TX_PARITY_EN
        if (k == 9)  return v.par;
        if (k == 10) return v.line[9];
`endif
        return v.line[k];
    endfunction

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        ld_tx_data = 1'b1;
        tx_data    = b;
        @(negedge clk);
        ld_tx_data = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (!tx_empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'd0, tx_empty}, 32'd1);
    endtask

    // Serial line monitor: samples mid-bit and scores bytes against exp_q.
    initial begin
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (!reset && tx_out == 1'b0) begin
                start_q.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                if (mon_en) check("mon_start", {31'd0, tx_out}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rx[i] = tx_out;
                end
`ifdef UART2_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                if (mon_en) check("mon_parity", {31'd0, tx_out}, {31'd0, ^rx});
`endif
                repeat (DIV) @(negedge clk);
                if (mon_en) begin
                    check("mon_stop", {31'd0, tx_out}, 32'd1);
                    if (exp_q.size() == 0)
                        check("mon_unexpected", {24'd0, rx}, 32'hFFFF_FFFF);
                    else
                        check("mon_data", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int off;
        bit quiet;
        logic [7:0] burst[6];

        vecs[0] = '{8'h55, 10'b1010101010, 1'b0};
        vecs[1] = '{8'h01, 10'b1000000010, 1'b1};
        vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[3] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[4] = '{8'h81, 10'b1100000010, 1'b0};
        vecs[5] = '{8'h07, 10'b1000001110, 1'b1};

        reset = 1'b1; tx_data = 8'h00; ld_tx_data = 1'b0; tx_enable = 1'b1;

        // Reset held for 100 ns
        #1;
        check("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check("rst_empty", {31'd0, tx_empty}, 32'd1);
        check("rst_full", {31'd0, tx_full}, 32'd0);
        check("rst_ovf", {31'd0, tx_overflow}, 32'd0);
        #98;
        check("rst_tx_out_end", {31'd0, tx_out}, 32'd1);
        #1 reset = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_empty !== 1'b1) quiet = 1'b0;
        end
        check("post_rst_quiet", {31'd0, quiet}, 32'd1);

        // Single frames with exact bit timing
        foreach (vecs[vi]) begin
            exp_q.push_back(vecs[vi].data);
            write_byte(vecs[vi].data);
            check("pre_fall_tx_out", {31'd0, tx_out}, 32'd1);
            check("empty_deassert", {31'd0, tx_empty}, 32'd0);
            @(negedge clk);
            check("fall_n2", {31'd0, tx_out}, 32'd0);
            off = 0;
            for (int k = 0; k < NB; k++) begin
                while (off < k * DIV + DIV / 2) begin
                    @(negedge clk);
                    off++;
                end
                check($sformatf("v%0d_bit%0d", vi, k), {31'd0, tx_out}, {31'd0, exp_bit(vecs[vi], k)});
            end
            while (off < FRAME - 1) begin
                @(negedge clk);
                off++;
            end
            check("last_stop_busy", {31'd0, tx_empty}, 32'd0);
            @(negedge clk);
            check("empty_after_frame", {31'd0, tx_empty}, 32'd1);
            check("idle_high", {31'd0, tx_out}, 32'd1);
            repeat (3) @(negedge clk);
        end

        // Burst, full, overflow, write+pop while full, back-to-back frames
        burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF;
        burst[3] = 8'h00; burst[4] = 8'h11; burst[5] = 8'h22;
        start_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(burst[i]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check("not_full_3", {31'd0, tx_full}, 32'd0);
            if (i == 5) check("full_after_5th", {31'd0, tx_full}, 32'd1);
            ld_tx_data = 1'b1;
            tx_data    = burst[i];
        end
        @(negedge clk);
        ld_tx_data = 1'b0;
        check("overflow_pulse", {31'd0, tx_overflow}, 32'd1);
        check("still_full", {31'd0, tx_full}, 32'd1);
        @(negedge clk);
        check("overflow_single", {31'd0, tx_overflow}, 32'd0);
        // Now just after edge 7; the first frame ends (and pops) at edge 2+FRAME.
        repeat (FRAME + 1 - 7) @(negedge clk);
        exp_q.push_back(8'h33);
        ld_tx_data = 1'b1;
        tx_data    = 8'h33;
        @(negedge clk);
        ld_tx_data = 1'b0;
        check("wr_pop_full_no_ovf", {31'd0, tx_overflow}, 32'd0);
        check("wr_pop_full_still_full", {31'd0, tx_full}, 32'd1);
        wait_empty("burst", 8 * FRAME);
        repeat (DIV) @(negedge clk);
        check("burst_all_sent", exp_q.size(), 32'd0);
        check("burst_frames", start_q.size(), 32'd6);
        for (int i = 1; i < 6 && i < start_q.size(); i++)
            check($sformatf("no_gap_%0d", i), start_q[i] - start_q[i-1], FRAME);

        // Enable gating
        tx_enable = 1'b0;
        exp_q.push_back(8'h42);
        write_byte(8'h42);
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx_out !== 1'b1) quiet = 1'b0;
        end
        check("gated_line_high", {31'd0, quiet}, 32'd1);
        check("gated_not_empty", {31'd0, tx_empty}, 32'd0);
        tx_enable = 1'b1;
        @(negedge clk);
        check("enable_start_1cyc", {31'd0, tx_out}, 32'd0);
        wait_empty("gated", 2 * FRAME);
        repeat (DIV) @(negedge clk);
        check("gated_sent", exp_q.size(), 32'd0);

        // Enable dropped during DATA: current frame completes, next byte waits
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        @(negedge clk);
        ld_tx_data = 1'b1; tx_data = 8'h81;
        @(negedge clk);
        tx_data = 8'h7E;
        @(negedge clk);
        ld_tx_data = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        tx_enable = 1'b0;
        repeat (FRAME) @(negedge clk);
        quiet = 1'b1;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (tx_out !== 1'b1) quiet = 1'b0;
        end
        check("drop_en_hold_high", {31'd0, quiet}, 32'd1);
        check("drop_en_first_done", exp_q.size(), 32'd1);
        check("drop_en_queued", {31'd0, tx_empty}, 32'd0);
        tx_enable = 1'b1;
        wait_empty("resume", 2 * FRAME);
        repeat (DIV) @(negedge clk);
        check("resume_sent", exp_q.size(), 32'd0);

        // Reset during DATA aborts the frame and empties the FIFO
        write_byte(8'h3C);
        write_byte(8'h5A);
        repeat (3 * DIV) @(negedge clk);
        check("pre_rst_busy", {31'd0, tx_empty}, 32'd0);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_line", {31'd0, tx_out}, 32'd1);
        check("async_rst_empty", {31'd0, tx_empty}, 32'd1);
        check("async_rst_full", {31'd0, tx_full}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_empty !== 1'b1) quiet = 1'b0;
        end
        check("post_abort_quiet", {31'd0, quiet}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
